// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
// Shared types and helpers for the wait-state MIPS memory model.
//   mem_state_t      : handshake FSM states
//   LANES            : byte lanes per 32-bit word
//   WAIT_CNT_W       : width of the wait-state down-counter
//   lane_byte()      : extracts byte lane i from a 32-bit word
//   word_idx_width() : word-index width for a given array size in bytes
package mips_mem_pkg;

    typedef enum logic [0:0] {
        IDLE,
        STALL
    } mem_state_t;

    localparam int LANES      = 4;
    localparam int WAIT_CNT_W = 4;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input int lane);
        return word[8*lane +: 8];
    endfunction

    // At least one index bit is kept so a single-word array still has a legal port width.
    function automatic int word_idx_width(input int depth_bytes);
        int words;
        words = depth_bytes / 4;
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mips_mem_byte_array.sv
// mips_mem_byte_array
// Byte-organised storage behind the memory model: one shared word index,
// four per-lane write enables, synchronous write and registered read.
// Contents are zeroed at time zero; reset never touches the storage.
// Ports:
//   clk    : rising-edge clock
//   we     : per-lane write enables (lane 0 = lowest byte address)
//   idx    : word index for both the write and the read
//   wdata  : write data, lane i in bits [8i+7:8i]
//   rd_en  : captures the addressed word into rdata at the clock edge
//   rdata  : registered read data, holds while rd_en is low
module mips_mem_byte_array
    import mips_mem_pkg::*;
#(
    parameter string RAM_INIT_FILE = "",
    parameter int    DEPTH_BYTES   = 4096
) (
    input  logic                                    clk,
    input  logic [LANES-1:0]                        we,
    input  logic [word_idx_width(DEPTH_BYTES)-1:0]  idx,
    input  logic [31:0]                             wdata,
    input  logic                                    rd_en,
    output logic [31:0]                             rdata
);

    localparam int IDX_W       = word_idx_width(DEPTH_BYTES);
    localparam int ADDR_W      = IDX_W + 2;
    // Rounded up to a power of two so the byte address indexes the array exactly;
    // bytes past DEPTH_BYTES are never reachable through the decoder.
    localparam int ARRAY_BYTES = 4 << IDX_W;

    logic [7:0] mem [ARRAY_BYTES];

    initial begin
        for (int i = 0; i < ARRAY_BYTES; i++) begin
            mem[ADDR_W'(i)] = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem[{idx, 2'(i)}] <= lane_byte(wdata, i);
            end
        end
        if (rd_en) begin
            rdata <= {mem[{idx, 2'd3}], mem[{idx, 2'd2}], mem[{idx, 2'd1}], mem[{idx, 2'd0}]};
        end
    end

endmodule

// File: rtl/mips_memory_wait.sv
// mips_memory_wait
// Word-aligned, byte-addressable RAM model for MIPS CPU testbenches with a
// programmable wait-state handshake, base-address decode and fault strobe.
// Each request is stalled WAIT_CYCLES cycles via waitrequest, accepted on the
// edge where waitrequest is low, and reads return data one cycle later.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   address        : byte address, held by the master while stalled
//   read, write    : request strobes (exactly one must be high to be legal)
//   byteenable     : lane i qualifies writedata[8i+7:8i]
//   writedata      : write data
//   waitrequest    : combinational stall for the current request
//   readdata       : read data, held until the next accepted read
//   readdatavalid  : one-cycle strobe qualifying readdata
//   fault          : one-cycle strobe for a rejected access
module mips_memory_wait
    import mips_mem_pkg::*;
#(
    parameter string       RAM_INIT_FILE = "",
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          DEPTH_BYTES   = 4096,
    parameter int          WAIT_CYCLES   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        fault
);

    localparam int                    IDX_W       = word_idx_width(DEPTH_BYTES);
    localparam logic [31:0]           LAST_OFFSET = 32'(DEPTH_BYTES - 4);
    localparam bit                    HAS_WAIT    = (WAIT_CYCLES > 0);
    // The IDLE cycle counts as the first stall cycle, so the counter is loaded with W-1.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD   = HAS_WAIT ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    mem_state_t            state;
    logic [WAIT_CNT_W-1:0] count;
    logic                  req;
    logic                  rd_op;
    logic                  legal;
    logic                  accept;
    logic [32:0]           diff;
    logic [IDX_W-1:0]      idx;
    logic [LANES-1:0]      we;
    logic                  rd_en;
    logic                  rd_zero;
    logic [31:0]           array_rdata;

    // The extra top bit of diff flags addresses below BASE_ADDR without a constant compare.
    always_comb begin
        req    = read | write;
        rd_op  = read & ~write;
        diff   = {1'b0, address} - {1'b0, BASE_ADDR};
        legal  = (read ^ write) && (address[1:0] == 2'b00) && !diff[32]
                 && (diff[31:0] <= LAST_OFFSET);
        idx    = diff[IDX_W+1:2];

        waitrequest = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                waitrequest = req && HAS_WAIT;
                accept      = req && !HAS_WAIT;
            end
            STALL: begin
                waitrequest = req && (count != '0);
                accept      = req && (count == '0);
            end
            default: begin
                waitrequest = 1'b0;
                accept      = 1'b0;
            end
        endcase

        // Reset wins over an acceptance in the same cycle, so it also blocks the array.
        we    = (accept && legal && write && !reset) ? byteenable : '0;
        rd_en = accept && legal && rd_op && !reset;
    end

    // rd_zero forces readdata to zero after reset or an illegal read, without a
    // second 32-bit register next to the array's read register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            readdatavalid <= 1'b0;
            fault         <= 1'b0;
            rd_zero       <= 1'b1;
        end else begin
            readdatavalid <= 1'b0;
            fault         <= 1'b0;

            case (state)
                IDLE: begin
                    if (req && HAS_WAIT) begin
                        state <= STALL;
                        count <= WAIT_LOAD;
                    end
                end
                STALL: begin
                    if (!req || count == '0) begin
                        state <= IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                fault <= !legal;
                if (rd_op) begin
                    readdatavalid <= 1'b1;
                    rd_zero       <= !legal;
                end
            end
        end
    end

    always_comb begin
        readdata = rd_zero ? 32'h0 : array_rdata;
    end

    mips_mem_byte_array #(
        .RAM_INIT_FILE (RAM_INIT_FILE),
        .DEPTH_BYTES   (DEPTH_BYTES)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .idx   (idx),
        .wdata (writedata),
        .rd_en (rd_en),
        .rdata (array_rdata)
    );

endmodule

// File: tb/tb_mips_memory_wait.sv
// tb_mips_memory_wait
// Three memory instances share one master bus; sel routes read/write to one of
//   dut0: WAIT_CYCLES=0, BASE 0x000, 64 bytes
//   dut1: WAIT_CYCLES=3, BASE 0x000, 64 bytes
//   dut2: WAIT_CYCLES=4, BASE 0x200, 64 bytes
// Accepted accesses push their expected strobes/data onto a queue tagged with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_mips_memory_wait;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [1:0]  sel;

    logic        rd_g  [3];
    logic        wr_g  [3];
    logic        wreq  [3];
    logic        rdv   [3];
    logic        flt   [3];
    logic [31:0] rdat  [3];

    logic        m_wait;
    logic        m_rdv;
    logic        m_flt;
    logic [31:0] m_rdat;

    always #5 clk = ~clk;

    assign rd_g[0] = read  && (sel == 2'd0);
    assign wr_g[0] = write && (sel == 2'd0);
    assign rd_g[1] = read  && (sel == 2'd1);
    assign wr_g[1] = write && (sel == 2'd1);
    assign rd_g[2] = read  && (sel == 2'd2);
    assign wr_g[2] = write && (sel == 2'd2);

    mips_memory_wait #(.RAM_INIT_FILE(""), .BASE_ADDR(32'h0000_0000), .DEPTH_BYTES(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .write(wr_g[0]), .read(rd_g[0]),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(wreq[0]),
        .readdata(rdat[0]), .readdatavalid(rdv[0]), .fault(flt[0]));

    mips_memory_wait #(.RAM_INIT_FILE(""), .BASE_ADDR(32'h0000_0000), .DEPTH_BYTES(64), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .address(address), .write(wr_g[1]), .read(rd_g[1]),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(wreq[1]),
        .readdata(rdat[1]), .readdatavalid(rdv[1]), .fault(flt[1]));

    mips_memory_wait #(.RAM_INIT_FILE(""), .BASE_ADDR(32'h0000_0200), .DEPTH_BYTES(64), .WAIT_CYCLES(4)) dut2 (
        .clk(clk), .reset(reset), .address(address), .write(wr_g[2]), .read(rd_g[2]),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(wreq[2]),
        .readdata(rdat[2]), .readdatavalid(rdv[2]), .fault(flt[2]));

    always_comb begin
        case (sel)
            2'd1:    begin m_wait = wreq[1]; m_rdv = rdv[1]; m_flt = flt[1]; m_rdat = rdat[1]; end
            2'd2:    begin m_wait = wreq[2]; m_rdv = rdv[2]; m_flt = flt[2]; m_rdat = rdat[2]; end
            default: begin m_wait = wreq[0]; m_rdv = rdv[0]; m_flt = flt[0]; m_rdat = rdat[0]; end
        endcase
    end

    function automatic int wcyc(input logic [1:0] s);
        case (s)
            2'd1:    return 3;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    typedef struct {
        int          due;
        logic        exp_rdv;
        logic        exp_flt;
        logic [31:0] exp_rdata;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        eflt;
        logic [31:0] erd;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (sel=%0d cycle=%0d)", name, got, want, sel, cyc);
        end
    endtask

    // Strobes are only allowed in the cycle an accepted access is due.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            checkOutput("readdatavalid", {31'b0, m_rdv}, {31'b0, mon_e.exp_rdv});
            checkOutput("fault", {31'b0, m_flt}, {31'b0, mon_e.exp_flt});
            if (mon_e.exp_rdv) begin
                checkOutput("readdata", m_rdat, mon_e.exp_rdata);
            end
        end else if (m_rdv || m_flt) begin
            checkOutput("stray_strobe", {30'b0, m_rdv, m_flt}, 32'h0);
        end
    end

    // Presents one request at the next cycle start, measures the stall and queues
    // the expectation; the request stays driven so the next call runs back-to-back.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wd,
                                 input logic eflt, input logic [31:0] erd);
        int   stalls;
        exp_t e;
        @(posedge clk); #1;
        read = rd; write = wr; address = addr; byteenable = be; writedata = wd;
        #1;
        stalls = 0;
        while (m_wait && stalls < 40) begin
            @(posedge clk); #2;
            stalls++;
        end
        checkOutput("stall_len", 32'(stalls), 32'(wcyc(sel)));
        if (!m_wait) begin
            e.due       = cyc + 1;
            e.exp_rdv   = rd && !wr;
            e.exp_flt   = eflt;
            e.exp_rdata = erd;
            sb.push_back(e);
        end
    endtask

    task automatic idleCycles(input int n);
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    vec_t tbl [17];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'd0,  4'hF,    32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'd0,  4'hF,    32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'd4,  4'hF,    32'h00000000, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'd4,  4'b0101, 32'hAABBCCDD, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'd4,  4'hF,    32'h0,        1'b0, 32'h00BB00DD};
        tbl[5]  = '{1'b1, 1'b0, 32'd2,  4'hF,    32'h0,        1'b1, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 32'd60, 4'hF,    32'h11223344, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 32'd64, 4'hF,    32'h99999999, 1'b1, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'd60, 4'hF,    32'h0,        1'b0, 32'h11223344};
        tbl[9]  = '{1'b1, 1'b1, 32'd0,  4'hF,    32'h55555555, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'd0,  4'h0,    32'h12121212, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'd0,  4'hF,    32'h0,        1'b0, 32'hDEADBEEF};
        tbl[12] = '{1'b1, 1'b0, 32'd64, 4'hF,    32'h0,        1'b1, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 32'd8,  4'hF,    32'h0,        1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 32'd60, 4'hF,    32'h0,        1'b0, 32'h11223344};
        tbl[15] = '{1'b0, 1'b1, 32'd32, 4'hF,    32'h12345678, 1'b0, 32'h0};
        tbl[16] = '{1'b1, 1'b0, 32'd32, 4'hF,    32'h0,        1'b0, 32'h12345678};

        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0;
        byteenable = '0; writedata = '0; sel = 2'd0;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_waitrequest", {31'b0, wreq[k]}, 32'h0);
            checkOutput("reset_readdatavalid", {31'b0, rdv[k]}, 32'h0);
            checkOutput("reset_fault", {31'b0, flt[k]}, 32'h0);
            checkOutput("reset_readdata", rdat[k], 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Same vector table against the zero-wait and three-wait instances.
        for (int s = 0; s < 2; s++) begin
            sel = 2'(s);
            $display("[TB] vector table on dut%0d", s);
            for (int i = 0; i < 17; i++) begin
                applyStimulus(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].be,
                              tbl[i].wd, tbl[i].eflt, tbl[i].erd);
            end
            idleCycles(3);
        end

        // dut2: base decode, abort and reset during a stall.
        sel = 2'd2;
        $display("[TB] hand sequences on dut2");
        applyStimulus(1'b0, 1'b1, 32'h200, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h204, 4'hF, 32'h01020304, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h1FC, 4'hF, 32'h0,        1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h23C, 4'hF, 32'h0,        1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h240, 4'hF, 32'h0,        1'b1, 32'h0);
        idleCycles(3);

        @(posedge clk); #1;
        write = 1'b1; address = 32'h200; byteenable = 4'hF; writedata = 32'h0BADBAD0;
        #1;
        checkOutput("abort_wait_c0", {31'b0, m_wait}, 32'h1);
        @(posedge clk); #2;
        checkOutput("abort_wait_c1", {31'b0, m_wait}, 32'h1);
        @(posedge clk); #1;
        write = 1'b0;
        #1;
        checkOutput("abort_wait_dropped", {31'b0, m_wait}, 32'h0);
        repeat (3) @(posedge clk);
        applyStimulus(1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D);
        idleCycles(3);

        @(posedge clk); #1;
        write = 1'b1; address = 32'h204; byteenable = 4'hF; writedata = 32'hFFFF0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("rst_stall_wait", {31'b0, m_wait}, 32'h1);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        checkOutput("rst_accept_wait", {31'b0, m_wait}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; write = 1'b0;
        #1;
        checkOutput("rst_after_wait", {31'b0, m_wait}, 32'h0);
        checkOutput("rst_after_rdv", {31'b0, m_rdv}, 32'h0);
        checkOutput("rst_after_fault", {31'b0, m_flt}, 32'h0);
        checkOutput("rst_after_readdata", m_rdat, 32'h0);
        repeat (2) @(posedge clk);
        applyStimulus(1'b1, 1'b0, 32'h204, 4'hF, 32'h0, 1'b0, 32'h01020304);
        idleCycles(3);

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
